// File: rtl/lbp_host_mem_if.sv
// Bus bundle between lbp_host_mem (slave) and the loader / LBP core / unloader side (master).
// wr_count and dup_err exist only when LBP_HOST_WRCHK_EN is defined.
interface lbp_host_mem_if #(
  parameter int AW = 14,
  parameter int DW = 8
);
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic          done;
`ifdef LBP_HOST_WRCHK_EN
  logic [AW:0]   wr_count;
  logic          dup_err;
`endif

  modport slave (
    input  ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, rd_ready,
    output ld_ready, gray_ready, gray_data, rd_valid, rd_addr, rd_data, done
`ifdef LBP_HOST_WRCHK_EN
    , output wr_count, dup_err
`endif
  );

  modport master (
    output ld_valid, ld_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, rd_ready,
    input  ld_ready, gray_ready, gray_data, rd_valid, rd_addr, rd_data, done
`ifdef LBP_HOST_WRCHK_EN
    , input wr_count, dup_err
`endif
  );
endinterface

// File: rtl/lbp_host_mem.sv
// Host-side frame/result memory for the LBP core: load stream, same-cycle gray reads,
// result capture and result dump stream. Optional write checker: LBP_HOST_WRCHK_EN.
module lbp_host_mem #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic         clk,
  input  logic         reset,
  lbp_host_mem_if.slave bus
);
  localparam int unsigned   DEPTH     = 1 << AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DUMP, ST_DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] rd_data_q;
  logic          rd_fetch;
  logic [AW-1:0] rd_fetch_addr;
  logic          gray_we;
  logic          res_we;
  logic [AW-1:0] res_waddr;
  logic [DW-1:0] res_wdata;

  logic [DW-1:0] gray_mem [DEPTH];
  logic [DW-1:0] res_mem  [DEPTH];

  always_comb begin
    state_d       = state_q;
    ld_cnt_d      = ld_cnt_q;
    rd_valid_d    = rd_valid_q;
    rd_addr_d     = rd_addr_q;
    rd_fetch      = 1'b0;
    rd_fetch_addr = rd_addr_q;
    gray_we       = 1'b0;
    res_we        = 1'b0;
    res_waddr     = ld_cnt_q;
    res_wdata     = '0;
    unique case (state_q)
      ST_LOAD: begin
        // Each load beat also clears the matching result entry.
        if (bus.ld_valid) begin
          gray_we = 1'b1;
          res_we  = 1'b1;
          if (ld_cnt_q == LAST_ADDR) state_d  = ST_SERVE;
          else                       ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
      ST_SERVE: begin
        if (bus.lbp_valid) begin
          res_we    = 1'b1;
          res_waddr = bus.lbp_addr;
          res_wdata = bus.lbp_data;
        end
        if (bus.finish) state_d = ST_DUMP;
      end
      ST_DUMP: begin
        // rd_data_q is the synchronous read port; the next entry is fetched on the
        // accepting edge so a continuously ready sink sees one beat per cycle.
        if (!rd_valid_q) begin
          rd_valid_d    = 1'b1;
          rd_addr_d     = '0;
          rd_fetch      = 1'b1;
          rd_fetch_addr = '0;
        end else if (bus.rd_ready) begin
          if (rd_addr_q == LAST_ADDR) begin
            rd_valid_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            rd_addr_d     = rd_addr_q + 1'b1;
            rd_fetch      = 1'b1;
            rd_fetch_addr = rd_addr_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      ld_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      if (rd_fetch) rd_data_q <= res_mem[rd_fetch_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && gray_we) gray_mem[ld_cnt_q] <= bus.ld_data;
    if (reset && res_we)  res_mem[res_waddr]  <= res_wdata;
  end

  assign bus.ld_ready   = (state_q == ST_LOAD);
  assign bus.gray_ready = (state_q == ST_SERVE);
  assign bus.gray_data  = ((state_q == ST_SERVE) && bus.gray_req) ? gray_mem[bus.gray_addr] : '0;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.done       = (state_q == ST_DONE);

`ifdef LBP_HOST_WRCHK_EN
  logic             svc_we;
  logic [DEPTH-1:0] wr_bit_q;
  logic [AW:0]      wr_count_q, wr_count_d;
  logic             dup_err_q, dup_err_d;

  assign svc_we = (state_q == ST_SERVE) && bus.lbp_valid;

  always_comb begin
    wr_count_d = wr_count_q + {{AW{1'b0}}, svc_we};
    dup_err_d  = dup_err_q | (svc_we & wr_bit_q[bus.lbp_addr]);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count_q <= '0;
      dup_err_q  <= 1'b0;
    end else begin
      wr_count_q <= wr_count_d;
      dup_err_q  <= dup_err_d;
    end
  end

  // Written bits behave like res_mem: not reset, cleared entry by entry while loading.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (gray_we)     wr_bit_q[ld_cnt_q]     <= 1'b0;
      else if (svc_we) wr_bit_q[bus.lbp_addr] <= 1'b1;
    end
  end

  assign bus.wr_count = wr_count_q;
  assign bus.dup_err  = dup_err_q;
`endif
endmodule

// File: tb/tb_lbp_host_mem.sv
// Self-checking bench for lbp_host_mem against an array-based reference of frame/result contents.
// Write-checker checks are compiled in when LBP_HOST_WRCHK_EN is defined.
module tb_lbp_host_mem;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lbp_host_mem_if #(.AW(AW), .DW(DW)) bus ();
  lbp_host_mem #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] gray_ref [N];
  logic [DW-1:0] res_ref  [N];
`ifdef LBP_HOST_WRCHK_EN
  bit            written  [N];
  int unsigned   wr_cnt_ref;
  bit            dup_ref;
`endif
  int total = 0;
  int bad   = 0;

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(N - 1));
  endfunction

  function automatic logic [DW-1:0] rdata();
    return DW'($urandom);
  endfunction

  task automatic idle();
    bus.ld_valid = 1'b0; bus.ld_data  = '0;
    bus.gray_req = 1'b0; bus.gray_addr = '0;
    bus.lbp_valid = 1'b0; bus.lbp_addr = '0; bus.lbp_data = '0;
    bus.finish = 1'b0; bus.rd_ready = 1'b0;
  endtask

  task automatic serve_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input bit we, input bit fin);
    @(posedge clk); #1;
    bus.gray_req = 1'b0;
    bus.lbp_valid = we; bus.lbp_addr = a; bus.lbp_data = d; bus.finish = fin;
    if (we) begin
      res_ref[a] = d;
`ifdef LBP_HOST_WRCHK_EN
      if (written[a]) dup_ref = 1'b1;
      written[a] = 1'b1;
      wr_cnt_ref++;
`endif
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b0; idle(); bus.gray_req = 1'b1; bus.gray_addr = raddr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.ld_ready, bus.gray_ready, bus.rd_valid, bus.done, bus.rd_addr, bus.rd_data, bus.gray_data}
        !== {1'b1, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_state: got ld_ready=%b gray_ready=%b rd_valid=%b done=%b rd_addr=%h rd_data=%h gray_data=%h, want 1 0 0 0 0 0 0",
               bus.ld_ready, bus.gray_ready, bus.rd_valid, bus.done, bus.rd_addr, bus.rd_data, bus.gray_data);
    end
`ifdef LBP_HOST_WRCHK_EN
    total++;
    if ({bus.wr_count, bus.dup_err} !== '0) begin
      bad++;
      $display("FAIL reset_wrchk: got wr_count=%0d dup_err=%b, want 0 0", bus.wr_count, bus.dup_err);
    end
    wr_cnt_ref = 0; dup_ref = 1'b0;
`endif
    @(posedge clk); #1;
    reset = 1'b1; bus.gray_req = 1'b0;
  endtask

  task automatic test_load(input bit gap, input bit ramp);
    int unsigned beats = 0;
    int unsigned cyc = 0;
    bit v;
    logic [DW-1:0] d;
    while (beats < N) begin
      @(posedge clk); #1;
      v = gap ? ((cyc % 3) != 2) : 1'b1;
      d = ramp ? DW'(beats) : rdata();
      bus.ld_valid = v; bus.ld_data = d;
      bus.gray_req = 1'b1; bus.gray_addr = raddr();
      bus.lbp_valid = 1'($urandom); bus.lbp_addr = raddr(); bus.lbp_data = rdata();
      bus.finish = 1'($urandom); bus.rd_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if ({bus.ld_ready, bus.gray_ready, bus.gray_data, bus.rd_valid, bus.done}
          !== {1'b1, 1'b0, {DW{1'b0}}, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL load_outputs: beat %0d got ld_ready=%b gray_ready=%b gray_data=%h rd_valid=%b done=%b, want 1 0 00 0 0",
                 beats, bus.ld_ready, bus.gray_ready, bus.gray_data, bus.rd_valid, bus.done);
      end
      if (v) begin
        gray_ref[beats] = d;
        res_ref[beats]  = '0;
`ifdef LBP_HOST_WRCHK_EN
        written[beats]  = 1'b0;
`endif
        beats++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    total++;
    if ({bus.ld_ready, bus.gray_ready} !== 2'b01) begin
      bad++;
      $display("FAIL load_end: got ld_ready=%b gray_ready=%b, want 0 1", bus.ld_ready, bus.gray_ready);
    end
  endtask

  task automatic test_read(input bit check_81);
    logic [AW-1:0] a;
    logic [DW-1:0] want;
    bit req;
    if (check_81) begin
      @(posedge clk); #1;
      bus.gray_req = 1'b1; bus.gray_addr = AW'('h81);
      @(negedge clk);
      total++;
      if (bus.gray_data !== 8'h81) begin
        bad++;
        $display("FAIL read_0x81: got %h, want 81", bus.gray_data);
      end
      @(posedge clk); #1;
      bus.gray_req = 1'b0;
      @(negedge clk);
      total++;
      if (bus.gray_data !== 8'h00) begin
        bad++;
        $display("FAIL read_noreq: got %h, want 00", bus.gray_data);
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      req = 1'($urandom); a = raddr();
      bus.gray_req = req; bus.gray_addr = a;
      @(negedge clk);
      want = req ? gray_ref[a] : '0;
      total++;
      if ({bus.gray_ready, bus.gray_data} !== {1'b1, want}) begin
        bad++;
        $display("FAIL read_rand: req=%b addr=%h got ready=%b data=%h, want ready=1 data=%h",
                 req, a, bus.gray_ready, bus.gray_data, want);
      end
    end
    @(posedge clk); #1;
    bus.gray_req = 1'b0;
  endtask

  task automatic test_capture();
    serve_write(AW'(5), 8'hA5, 1'b1, 1'b0);
    serve_write(AW'(N - 1), 8'h3C, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.lbp_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.gray_ready, bus.rd_valid} !== 2'b10) begin
      bad++;
      $display("FAIL capture_serve: got gray_ready=%b rd_valid=%b, want 1 0", bus.gray_ready, bus.rd_valid);
    end
    serve_write(AW'(6), 8'h11, 1'b1, 1'b1);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic test_dump(input int mode, input int stop_at, output bit stopped);
    int unsigned cyc = 0;
    int nxt = 0;
    bit seen = 1'b0;
    bit fin = 1'b0;
    bit r;
    stopped = 1'b0;
    while (cyc < 4 * N + 64 && !fin && !stopped) begin
      @(posedge clk); #1;
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: r = 1'($urandom);
      endcase
      bus.rd_ready = r;
      bus.lbp_valid = 1'($urandom); bus.lbp_addr = raddr(); bus.lbp_data = rdata();
      bus.finish = 1'($urandom); bus.ld_valid = 1'($urandom); bus.ld_data = rdata();
      bus.gray_req = 1'b1; bus.gray_addr = raddr();
      @(negedge clk);
      total++;
      if ({bus.ld_ready, bus.gray_ready, bus.gray_data, bus.done} !== '0) begin
        bad++;
        $display("FAIL dump_side: got ld_ready=%b gray_ready=%b gray_data=%h done=%b, want all 0",
                 bus.ld_ready, bus.gray_ready, bus.gray_data, bus.done);
      end
      if (bus.rd_valid) begin
        if (!seen) begin
          seen = 1'b1;
          total++;
          if (cyc > 2) begin
            bad++;
            $display("FAIL dump_first_valid: got rd_valid after %0d cycles, want <= 2", cyc);
          end
        end
        total++;
        if (bus.rd_addr !== AW'(nxt) || bus.rd_data !== res_ref[nxt]) begin
          bad++;
          $display("FAIL dump_beat: got addr=%h data=%h, want addr=%h data=%h",
                   bus.rd_addr, bus.rd_data, AW'(nxt), res_ref[nxt]);
        end
        if (stop_at >= 0 && nxt == stop_at) stopped = 1'b1;
        else if (r) begin
          nxt++;
          if (nxt == N) fin = 1'b1;
        end
      end else if (seen) begin
        total++; bad++;
        $display("FAIL dump_valid_drop: got rd_valid=0 before beat %0d, want 1", nxt);
      end
      cyc++;
    end
    if (!fin && !stopped) begin
      total++; bad++;
      $display("FAIL dump_timeout: got %0d beats, want %0d", nxt, N);
    end
    if (fin) begin
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      total++;
      if ({bus.rd_valid, bus.done} !== 2'b01) begin
        bad++;
        $display("FAIL dump_end: got rd_valid=%b done=%b, want 0 1", bus.rd_valid, bus.done);
      end
    end
  endtask

  task automatic test_backpressure();
    bit stopped;
    test_dump(1, -1, stopped);
  endtask

  task automatic test_done();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.ld_valid = 1'($urandom); bus.ld_data = rdata();
      bus.gray_req = 1'b1; bus.gray_addr = raddr();
      bus.lbp_valid = 1'($urandom); bus.lbp_addr = raddr(); bus.lbp_data = rdata();
      bus.finish = 1'($urandom); bus.rd_ready = 1'($urandom);
      @(negedge clk);
      total++;
      if ({bus.done, bus.rd_valid, bus.ld_ready, bus.gray_ready, bus.gray_data}
          !== {1'b1, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}) begin
        bad++;
        $display("FAIL done_hold: got done=%b rd_valid=%b ld_ready=%b gray_ready=%b gray_data=%h, want 1 0 0 0 00",
                 bus.done, bus.rd_valid, bus.ld_ready, bus.gray_ready, bus.gray_data);
      end
`ifdef LBP_HOST_WRCHK_EN
      total++;
      if ({bus.wr_count, bus.dup_err} !== {(AW + 1)'(wr_cnt_ref), dup_ref}) begin
        bad++;
        $display("FAIL done_wrchk: got wr_count=%0d dup_err=%b, want %0d %b",
                 bus.wr_count, bus.dup_err, wr_cnt_ref, dup_ref);
      end
`endif
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset_mid();
    bit stopped;
    test_reset();
    test_load(1'b0, 1'b0);
    test_read(1'b0);
    serve_write('0, '0, 1'b0, 1'b1);
    test_dump(2, 100, stopped);
    total++;
    if (!stopped) begin
      bad++;
      $display("FAIL reset_mid_reach: got stopped=0, want dump to reach beat 100");
    end
    @(posedge clk); #1;
    reset = 1'b0; idle();
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.rd_valid, bus.done, bus.ld_ready, bus.gray_ready} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_mid: got rd_valid=%b done=%b ld_ready=%b gray_ready=%b, want 0 0 1 0",
               bus.rd_valid, bus.done, bus.ld_ready, bus.gray_ready);
    end
`ifdef LBP_HOST_WRCHK_EN
    wr_cnt_ref = 0; dup_ref = 1'b0;
`endif
    @(posedge clk); #1;
    reset = 1'b1;
    test_load(1'b0, 1'b0);
    serve_write('0, '0, 1'b0, 1'b1);
    test_dump(0, -1, stopped);
    test_done();
  endtask

  task automatic test_dup_writes();
    bit stopped;
    test_reset();
    test_load(1'b0, 1'b0);
    for (int k = 0; k < 40; k++) serve_write(AW'(k * 97 + 300), rdata(), 1'b1, 1'b0);
    serve_write(AW'(7), rdata(), 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.lbp_valid = 1'b0;
    @(negedge clk);
`ifdef LBP_HOST_WRCHK_EN
    total++;
    if ({bus.dup_err, bus.wr_count} !== {dup_ref, (AW + 1)'(wr_cnt_ref)}) begin
      bad++;
      $display("FAIL dup_first: got dup_err=%b wr_count=%0d, want %b %0d",
               bus.dup_err, bus.wr_count, dup_ref, wr_cnt_ref);
    end
`endif
    serve_write(AW'(7), rdata(), 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.lbp_valid = 1'b0;
    @(negedge clk);
`ifdef LBP_HOST_WRCHK_EN
    total++;
    if ({bus.dup_err, bus.wr_count} !== {1'b1, (AW + 1)'(wr_cnt_ref)}) begin
      bad++;
      $display("FAIL dup_second: got dup_err=%b wr_count=%0d, want 1 %0d",
               bus.dup_err, bus.wr_count, wr_cnt_ref);
    end
`endif
    test_read(1'b0);
    serve_write(raddr(), rdata(), 1'b1, 1'b1);
    test_dump(2, -1, stopped);
    test_done();
  endtask

  initial begin
    idle();
    test_reset();
    test_load(1'b1, 1'b1);
    test_read(1'b1);
    test_capture();
    test_backpressure();
    test_done();
    test_reset_mid();
    test_dup_writes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lbp_host_mem.md
Name: lbp_host_mem

Overview:
- Synthesizable host-side responder for the LBP core's image and result interfaces.
- Holds the grayscale frame, serves the core's `gray_req`/`gray_addr` reads with same-cycle data, and captures `lbp_valid` result writes into a result memory.
- Before processing, the frame is loaded over a valid/ready stream. After the core asserts `finish`, the result frame is streamed out over a valid/ready stream.
- Sits between the system loader/unloader and the LBP core. It replaces the behavioural memories used in simulation.

Parameters:
- AW, 14, address width; both memories have 2^AW entries.
- DW, 8, pixel width of gray and result data.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ld_valid  in  1  load stream beat valid.
- ld_data  in  DW  load pixel, raster order starting at address 0.
- ld_ready  out  1  host accepts load beats.
- gray_req  in  1  core read request.
- gray_addr  in  AW  core read address.
- gray_ready  out  1  frame loaded; core may start.
- gray_data  out  DW  read data.
- lbp_valid  in  1  core result write strobe.
- lbp_addr  in  AW  result address.
- lbp_data  in  DW  result data.
- finish  in  1  core done.
- rd_valid  out  1  dump beat valid.
- rd_addr  out  AW  dump beat address.
- rd_data  out  DW  dump beat data.
- rd_ready  in  1  downstream accepts dump beat.
- done  out  1  dump complete.

Behaviour:
- Reset (reset==0 at posedge): state=LOAD, counters=0, ld_ready=1, gray_ready=0, rd_valid=0, rd_addr=0, rd_data=0, done=0. Memory contents are not cleared by reset.
- State LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid=1 writes gray_mem[ld_cnt]<=ld_data, writes res_mem[ld_cnt]<=0 (result clear), and increments ld_cnt.
  - The beat at ld_cnt==2^AW-1 moves the state to SERVE. ld_ready=0 from the next cycle.
- State SERVE:
  - gray_ready=1 (registered; first high cycle is the cycle after the last load beat).
  - gray_data = gray_req ? gray_mem[gray_addr] : 0. This is a combinational read, valid in the same cycle as the request, with no wait states. gray_data is never tristated.
  - lbp_valid=1 at posedge writes res_mem[lbp_addr]<=lbp_data. Later writes to the same address overwrite earlier ones.
  - finish==1 at posedge moves the state to DUMP. A write with lbp_valid in that same cycle is still committed. gray_ready=0 from the next cycle.
- State DUMP:
  - Streams res_mem[0..2^AW-1] in address order.
  - rd_valid rises within 2 cycles of entering DUMP.
  - A beat transfers when rd_valid&rd_ready.
  - While rd_valid&!rd_ready, rd_addr and rd_data are held stable.
  - A synchronous res_mem read with prefetch is permitted, provided it yields no bubbles when rd_ready is held 1 (one beat per cycle after the first).
  - The transfer with rd_addr==2^AW-1 moves the state to DONE. rd_valid=0 next cycle.
- State DONE: done=1, held until reset. All inputs are ignored.
- Outside SERVE: gray_data=0, and lbp_valid and finish are ignored.
- Outside LOAD: ld_valid is ignored.
- Counter wrap: ld_cnt and the dump counter never wrap; state exits occur at the terminal count.
- Reset mid-operation, any state: immediate return to LOAD as listed under Reset. Any partial dump is abandoned.

Optional Feature:
- Macro: LBP_HOST_WRCHK_EN.
- When defined:
  - Adds outputs wr_count (AW+1 bits) and dup_err (1 bit).
  - wr_count counts accepted lbp_valid writes in SERVE.
  - A per-address written-bit array is cleared during LOAD alongside res_mem.
  - dup_err goes high the cycle after a write hits an already-written address, and is sticky until reset.
  - Both outputs are 0 on reset.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Load ramp: ld_data=i[7:0] for 16384 consecutive beats, with ld_valid gapped every 3rd cycle. Expected: ld_ready drops after beat 16383, gray_ready=1 the following cycle, and no beat is lost.
- Read: in SERVE, gray_req=1, gray_addr=0x0081 gives gray_data=0x81 in the same cycle. gray_req=0 gives gray_data=0x00.
- Capture: lbp_valid with addr 5/0xA5 and addr 16383/0x3C, then finish with a simultaneous write of addr 6/0x11. Expected dump: beat 5=0xA5, beat 6=0x11, beat 16383=0x3C, all others 0x00.
- Backpressure: rd_ready toggling 1,0,0,1. Expected: exactly 16384 beats with addresses 0..16383 in order, data held while stalled, done=1 after the last transfer.
- Reset at dump beat 100. Expected: next cycle rd_valid=0, done=0, ld_ready=1, gray_ready=0. A reload followed by finish dumps all zeros.
- Feature on: two writes to addr 7. Expected: wr_count=2, dup_err=1 one cycle after the second write, still 1 in DONE.
